// File: rtl/frame_plotter.sv
// Framebuffer write-port producer: clears the 1-bit framebuffer on request,
// then plots each accepted particle as a DOT_SIZE x DOT_SIZE square clipped to the screen.
module frame_plotter #(
  parameter int DRAW_WIDTH  = 640,
  parameter int DRAW_HEIGHT = 480,
  parameter int DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
  parameter int DRAW_ADDRW  = $clog2(DRAW_SIZE),
  parameter int DRAW_DATAW  = 1,
  parameter int DOT_SIZE    = 2,
  parameter int COORDW      = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [COORDW-1:0]     pt_x,
  input  logic [COORDW-1:0]     pt_y,
  input  logic                  pt_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DRAW_ADDRW-1:0] draw_addr_write,
  output logic [DRAW_DATAW-1:0] draw_data_in,
  output logic                  draw_we,
  output logic [2:0]            dbg_state
);

  // Handshake: a particle transfers on a rising clk edge where pt_valid && pt_ready;
  // upstream holds pt_valid and data stable until then, pt_ready is only high in WAIT_PT.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PLOT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DOTW = (DOT_SIZE > 1) ? $clog2(DOT_SIZE) : 1;
  localparam int PW   = COORDW + 1;

  localparam logic [DRAW_ADDRW-1:0] ADDR_LAST = DRAW_ADDRW'(DRAW_SIZE - 1);
  localparam logic [DOTW-1:0]       DOT_LAST  = DOTW'(DOT_SIZE - 1);
  localparam logic [31:0]           W_LIM     = DRAW_WIDTH;
  localparam logic [31:0]           H_LIM     = DRAW_HEIGHT;

  logic [2:0]            r_state;
  logic [DRAW_ADDRW-1:0] r_clr_cnt;
  logic [COORDW-1:0]     r_x;
  logic [COORDW-1:0]     r_y;
  logic                  r_last;
  logic [DOTW-1:0]       r_dx;
  logic [DOTW-1:0]       r_dy;
  logic                  r_pt_ready;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_we;
  logic [DRAW_ADDRW-1:0] r_addr;
  logic [DRAW_DATAW-1:0] r_data;

  logic [2:0]            w_next;
  logic [PW-1:0]         w_px;
  logic [PW-1:0]         w_py;
  logic                  w_in_bounds;
  logic [DRAW_ADDRW-1:0] w_pix_addr;
  logic                  w_accept;
  logic                  w_clr_last;
  logic                  w_pix_last;

  // One extra bit on the pixel coordinate keeps x+dx from wrapping back on-screen.
  assign w_px        = PW'(r_x) + PW'(r_dx);
  assign w_py        = PW'(r_y) + PW'(r_dy);
  assign w_in_bounds = (32'(w_px) < W_LIM) && (32'(w_py) < H_LIM);
  assign w_pix_addr  = DRAW_ADDRW'(w_py) * DRAW_ADDRW'(DRAW_WIDTH) + DRAW_ADDRW'(w_px);
  assign w_accept    = (r_state == S_WAIT) && pt_valid && r_pt_ready;
  assign w_clr_last  = (r_clr_cnt == ADDR_LAST);
  assign w_pix_last  = (r_dx == DOT_LAST) && (r_dy == DOT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (frame_start) w_next = S_CLEAR;
      S_CLEAR: if (w_clr_last) w_next = S_WAIT;
      S_WAIT:  if (w_accept) w_next = S_PLOT;
      S_PLOT:  if (w_pix_last) w_next = r_last ? S_DONE : S_WAIT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_last       <= 1'b0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_pt_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_state      <= w_next;
      r_pt_ready   <= (w_next == S_WAIT);
      r_busy       <= (w_next != S_IDLE);
      r_frame_done <= (w_next == S_DONE);
      r_we         <= 1'b0;
      r_data       <= '0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) r_clr_cnt <= '0;
        end
        S_CLEAR: begin
          r_we      <= 1'b1;
          r_addr    <= r_clr_cnt;
          r_clr_cnt <= r_clr_cnt + 1'b1;
        end
        S_WAIT: begin
          if (w_accept) begin
            r_x    <= pt_x;
            r_y    <= pt_y;
            r_last <= pt_last;
            r_dx   <= '0;
            r_dy   <= '0;
          end
        end
        S_PLOT: begin
          // Clipped pixels still consume their cycle, just without a write.
          if (w_in_bounds) begin
            r_we   <= 1'b1;
            r_addr <= w_pix_addr;
            r_data <= '1;
          end
          if (r_dx == DOT_LAST) begin
            r_dx <= '0;
            r_dy <= r_dy + 1'b1;
          end else begin
            r_dx <= r_dx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pt_ready        = r_pt_ready;
  assign busy            = r_busy;
  assign frame_done      = r_frame_done;
  assign draw_we         = r_we;
  assign draw_addr_write = r_addr;
  assign draw_data_in    = r_data;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_frame_plotter.sv
// Bench for frame_plotter on an 8x4 screen with 2x2 dots: a reference model queues the
// expected write/done stream per stimulus and a negedge monitor compares what the DUT emits.
module tb_frame_plotter;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int SZ  = W * H;
  localparam int AW  = $clog2(SZ);
  localparam int DW  = 1;
  localparam int DOT = 2;
  localparam int CW  = 10;
  localparam int EW  = 1 + DW + AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_start;
  logic          pt_valid;
  logic          pt_ready;
  logic [CW-1:0] pt_x;
  logic [CW-1:0] pt_y;
  logic          pt_last;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] draw_addr_write;
  logic [DW-1:0] draw_data_in;
  logic          draw_we;
  logic [2:0]    dbg_state;

  frame_plotter #(
    .DRAW_WIDTH (W),
    .DRAW_HEIGHT(H),
    .DOT_SIZE   (DOT),
    .COORDW     (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .pt_valid       (pt_valid),
    .pt_ready       (pt_ready),
    .pt_x           (pt_x),
    .pt_y           (pt_y),
    .pt_last        (pt_last),
    .busy           (busy),
    .frame_done     (frame_done),
    .draw_addr_write(draw_addr_write),
    .draw_data_in   (draw_data_in),
    .draw_we        (draw_we),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry = {is_done, data, addr}; a done entry carries zero data/addr.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_clear();
    for (int i = 0; i < SZ; i++) exp_q.push_back({1'b0, {DW{1'b0}}, AW'(i)});
  endfunction

  // Square of side DOT anchored at (x,y), row by row, keeping only on-screen pixels.
  function automatic void push_point(input int x, input int y, input bit last);
    for (int dy = 0; dy < DOT; dy++)
      for (int dx = 0; dx < DOT; dx++)
        if (x + dx < W && y + dy < H)
          exp_q.push_back({1'b0, {DW{1'b1}}, AW'((y + dy) * W + (x + dx))});
    if (last) exp_q.push_back({1'b1, {DW{1'b0}}, {AW{1'b0}}});
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (draw_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", draw_addr_write, draw_data_in);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", 32'({1'b0, draw_data_in, draw_addr_write}), 32'(mon_e));
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got frame_done 1, expected no event");
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_done", 32'({1'b1, {DW{1'b0}}, {AW{1'b0}}}), 32'(mon_e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input bit mid_pulse);
    int n;
    push_clear();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      frame_start = (mid_pulse && n == 10);
      if (pt_ready) break;
    end
    frame_start = 1'b0;
    check("clear_cycles_to_ready", n, SZ);
  endtask

  task automatic send_point(input int x, input int y, input bit last);
    bit acc;
    push_point(x, y, last);
    pt_x     = CW'(x);
    pt_y     = CW'(y);
    pt_last  = last;
    pt_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (pt_ready) begin
        @(posedge clk);
        #1 acc = 1'b1;
        break;
      end
    end
    pt_valid = 1'b0;
    check("point_accepted", acc, 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_seen", seen, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("we_after_done", draw_we, 0);
    check("done_one_cycle", frame_done, 0);
  endtask

  task automatic reset_mid_clear();
    bit hit;
    push_clear();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (draw_we && draw_addr_write == AW'(13)) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_clear_addr_13", hit, 1);
    #2 reset_n = 1'b0;
    #1;
    check("we_cleared_by_async_reset", draw_we, 0);
    check("busy_cleared_by_async_reset", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int np;
    int rx;
    int ry;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    pt_valid    = 1'b1;
    pt_x        = CW'(3);
    pt_y        = CW'(1);
    pt_last     = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_we", draw_we, 0);
    check("rst_ready", pt_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_addr", draw_addr_write, 0);
    check("rst_data", draw_data_in, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("idle_ready_low", pt_ready, 0);
      check("idle_no_write", draw_we, 0);
    end
    pt_valid = 1'b0;

    // single on-screen particle
    start_frame(1'b0);
    send_point(2, 1, 1'b1);
    wait_done();

    // corner-clipped particle followed by origin particle
    start_frame(1'b0);
    send_point(7, 3, 1'b0);
    send_point(0, 0, 1'b1);
    wait_done();

    // point held valid through the clear, plus an ignored mid-clear frame_start
    pt_x     = CW'(1);
    pt_y     = CW'(1);
    pt_last  = 1'b1;
    pt_valid = 1'b1;
    start_frame(1'b1);
    send_point(1, 1, 1'b1);
    wait_done();

    // randomized frames, including far off-screen coordinates near the COORDW limit
    repeat (6) begin
      start_frame(1'b0);
      np = $urandom_range(1, 4);
      for (int i = 0; i < np; i++) begin
        rx = ($urandom_range(0, 7) == 0) ? $urandom_range(1015, 1023) : $urandom_range(0, W);
        ry = ($urandom_range(0, 7) == 0) ? $urandom_range(1015, 1023) : $urandom_range(0, H);
        send_point(rx, ry, i == np - 1);
      end
      wait_done();
    end

    // reset in the middle of a clear, then a full frame restarting at address 0
    reset_mid_clear();
    start_frame(1'b0);
    send_point(5, 2, 1'b1);
    wait_done();

    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
